// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU among NUM_REQ requesters
// A one-entry response register returns result, zero flag and tag to the winning requester.
package alu_arbiter_pkg;
   localparam int DATA_WIDTH = 32;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_sel_e;
endpackage

module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int TAG_W   = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_REQ-1:0]                 req_valid_i,
   output logic [NUM_REQ-1:0]                 req_ready_o,
   input  alu_sel_e [NUM_REQ-1:0]             req_alu_sel_i,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_op1_i,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_op2_i,
   input  logic [NUM_REQ-1:0][TAG_W-1:0]      req_tag_i,
   output alu_sel_e                           alu_sel_o,
   output logic [DATA_WIDTH-1:0]              alu_op1_o,
   output logic [DATA_WIDTH-1:0]              alu_op2_o,
   input  logic [DATA_WIDTH-1:0]              alu_result_i,
   input  logic                               alu_zero_i,
   output logic [NUM_REQ-1:0]                 rsp_valid_o,
   input  logic [NUM_REQ-1:0]                 rsp_ready_i,
   output logic [DATA_WIDTH-1:0]              rsp_result_o,
   output logic                               rsp_zero_o,
   output logic [TAG_W-1:0]                   rsp_tag_o
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic                  rsp_valid_q,  rsp_valid_d;
   logic [IDX_W-1:0]      rsp_owner_q,  rsp_owner_d;
   logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic                  rsp_zero_q,   rsp_zero_d;
   logic [TAG_W-1:0]      rsp_tag_q,    rsp_tag_d;
   logic [IDX_W-1:0]      rr_ptr_q,     rr_ptr_d;

   logic [NUM_REQ-1:0]    grant;
   logic [IDX_W-1:0]      grant_idx;
   logic [IDX_W-1:0]      scan_idx;
   logic                  grant_any;
   logic                  can_accept;
   logic                  accept;

   // Scan starts one past the last accepted requester so every valid requester is reached.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      scan_idx  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!grant_any && req_valid_i[scan_idx]) begin
            grant_any        = 1'b1;
            grant_idx        = scan_idx;
            grant[scan_idx]  = 1'b1;
         end
      end
   end

   assign can_accept = !rsp_valid_q || rsp_ready_i[rsp_owner_q];
   assign accept     = |(req_valid_i & req_ready_o);

   always_comb begin
      req_ready_o = '0;
      if (rst_n && grant_any && can_accept) begin
         req_ready_o = grant;
      end
   end

   always_comb begin
      alu_sel_o = ALU_PASS_B;
      alu_op1_o = '0;
      alu_op2_o = '0;
      if (grant_any) begin
         alu_sel_o = req_alu_sel_i[grant_idx];
         alu_op1_o = req_op1_i[grant_idx];
         alu_op2_o = req_op2_i[grant_idx];
      end
   end

   // A new accept overwrites the slot even when the old response drains in the same cycle.
   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_owner_d  = rsp_owner_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_tag_d    = rsp_tag_q;
      rr_ptr_d     = rr_ptr_q;
      if (accept) begin
         rsp_valid_d  = 1'b1;
         rsp_owner_d  = grant_idx;
         rsp_result_d = alu_result_i;
         rsp_zero_d   = alu_zero_i;
         rsp_tag_d    = req_tag_i[grant_idx];
         rr_ptr_d     = grant_idx;
      end else if (rsp_valid_q && rsp_ready_i[rsp_owner_q]) begin
         rsp_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q  <= 1'b0;
         rsp_owner_q  <= '0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_tag_q    <= '0;
         rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_owner_q  <= rsp_owner_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_tag_q    <= rsp_tag_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   always_comb begin
      rsp_valid_o              = '0;
      rsp_valid_o[rsp_owner_q] = rsp_valid_q;
   end

   assign rsp_result_o = rsp_result_q;
   assign rsp_zero_o   = rsp_zero_q;
   assign rsp_tag_o    = rsp_tag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural ALU and arbiter model
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   localparam int N  = 2;
   localparam int TW = 4;

   function automatic logic [31:0] alu_ref(input alu_sel_e s, input logic [31:0] a, input logic [31:0] b);
      case (s)
         ALU_ADD:    return a + b;
         ALU_SUB:    return a - b;
         ALU_SLL:    return a << b[4:0];
         ALU_SLT:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
         ALU_XOR:    return a ^ b;
         ALU_SRL:    return a >> b[4:0];
         ALU_SRA:    return $signed(a) >>> b[4:0];
         ALU_OR:     return a | b;
         ALU_AND:    return a & b;
         ALU_PASS_B: return b;
         default:    return 32'd0;
      endcase
   endfunction

   logic                 clk, rst_n;
   logic [N-1:0]         req_valid, req_ready, rsp_valid, rsp_ready;
   alu_sel_e [N-1:0]     req_sel;
   logic [N-1:0][31:0]   req_op1, req_op2;
   logic [N-1:0][TW-1:0] req_tag;
   alu_sel_e             alu_sel;
   logic [31:0]          alu_op1, alu_op2, alu_result, rsp_result;
   logic                 alu_zero, rsp_zero;
   logic [TW-1:0]        rsp_tag;

   logic [2:0]           v3, r3, rv3, rr3;
   alu_sel_e [2:0]       sel3;
   logic [2:0][31:0]     a3, b3;
   logic [2:0][TW-1:0]   t3;
   alu_sel_e             alu_sel3;
   logic [31:0]          ao1_3, ao2_3, ares3, rres3;
   logic                 azero3, rz3;
   logic [TW-1:0]        rt3;

   int checks = 0;
   int errors = 0;

   bit          m_valid;
   int          m_owner, m_last;
   logic [31:0] m_result;
   logic        m_zero;
   logic [TW-1:0] m_tag;

   assign alu_result = alu_ref(alu_sel, alu_op1, alu_op2);
   assign alu_zero   = (alu_result == 32'd0);
   assign ares3      = alu_ref(alu_sel3, ao1_3, ao2_3);
   assign azero3     = (ares3 == 32'd0);

   alu_arbiter #(.NUM_REQ(N), .TAG_W(TW)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_alu_sel_i(req_sel), .req_op1_i(req_op1), .req_op2_i(req_op2), .req_tag_i(req_tag),
      .alu_sel_o(alu_sel), .alu_op1_o(alu_op1), .alu_op2_o(alu_op2),
      .alu_result_i(alu_result), .alu_zero_i(alu_zero),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero), .rsp_tag_o(rsp_tag)
   );

   alu_arbiter #(.NUM_REQ(3), .TAG_W(TW)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(v3), .req_ready_o(r3),
      .req_alu_sel_i(sel3), .req_op1_i(a3), .req_op2_i(b3), .req_tag_i(t3),
      .alu_sel_o(alu_sel3), .alu_op1_o(ao1_3), .alu_op2_o(ao2_3),
      .alu_result_i(ares3), .alu_zero_i(azero3),
      .rsp_valid_o(rv3), .rsp_ready_i(rr3),
      .rsp_result_o(rres3), .rsp_zero_o(rz3), .rsp_tag_o(rt3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid  = 1'b0;
      m_owner  = 0;
      m_last   = N - 1;
      m_result = '0;
      m_zero   = 1'b0;
      m_tag    = '0;
   endtask

   // Called at a falling edge with inputs already driven; compares, then advances one clock.
   task automatic cycle();
      int w;
      logic can;
      logic [N-1:0] er, ev;
      #1;
      w = -1;
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (m_last + k) % N;
         if (w < 0 && req_valid[j]) w = j;
      end
      can = !m_valid || rsp_ready[m_owner];
      er  = (w >= 0 && can) ? N'(1 << w) : '0;
      check("req_ready", req_ready, er);
      if (w >= 0) begin
         check("alu_sel", alu_sel, req_sel[w]);
         check("alu_op1", alu_op1, req_op1[w]);
         check("alu_op2", alu_op2, req_op2[w]);
      end else begin
         check("idle_sel", alu_sel, ALU_PASS_B);
         check("idle_op1", alu_op1, 32'd0);
         check("idle_op2", alu_op2, 32'd0);
      end
      ev = m_valid ? N'(1 << m_owner) : '0;
      check("rsp_valid", rsp_valid, ev);
      if (m_valid) begin
         check("rsp_result", rsp_result, m_result);
         check("rsp_zero", rsp_zero, m_zero);
         check("rsp_tag", rsp_tag, m_tag);
      end
      @(posedge clk);
      if (er != '0) begin
         m_result = alu_ref(req_sel[w], req_op1[w], req_op2[w]);
         m_zero   = (m_result == 32'd0);
         m_tag    = req_tag[w];
         m_owner  = w;
         m_valid  = 1'b1;
         m_last   = w;
      end else if (m_valid && rsp_ready[m_owner]) begin
         m_valid = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = '0;
      v3        = '0;
      rr3       = '0;
      for (int r = 0; r < N; r++) begin
         req_sel[r] = ALU_ADD;
         req_op1[r] = '0;
         req_op2[r] = '0;
         req_tag[r] = '0;
      end
      for (int r = 0; r < 3; r++) begin
         sel3[r] = ALU_ADD;
         a3[r]   = 32'(r);
         b3[r]   = 32'd1;
         t3[r]   = TW'(r);
      end
      model_reset();

      repeat (2) @(negedge clk);
      req_valid = 2'b11;
      #1;
      check("reset_req_ready", req_ready, 2'b00);
      check("reset_rsp_valid", rsp_valid, 2'b00);
      check("reset_rsp_result", rsp_result, 32'd0);
      check("reset_rsp_zero", rsp_zero, 1'b0);
      check("reset_rsp_tag", rsp_tag, 4'd0);
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // single ADD request
      req_valid  = 2'b01;
      req_sel[0] = ALU_ADD;
      req_op1[0] = 32'd5;
      req_op2[0] = 32'd7;
      req_tag[0] = 4'd3;
      rsp_ready  = 2'b01;
      cycle();
      req_valid = '0;
      #1;
      check("add_rsp_valid", rsp_valid, 2'b01);
      check("add_result", rsp_result, 32'd12);
      check("add_zero", rsp_zero, 1'b0);
      check("add_tag", rsp_tag, 4'd3);
      cycle();

      // contested, alternating grants
      req_valid  = 2'b11;
      req_sel[0] = ALU_SUB;
      req_op1[0] = 32'd9;
      req_op2[0] = 32'd9;
      req_tag[0] = 4'd1;
      req_sel[1] = ALU_OR;
      req_op1[1] = 32'hF0;
      req_op2[1] = 32'h0F;
      req_tag[1] = 4'd2;
      rsp_ready  = 2'b11;
      for (int i = 0; i < 4; i++) begin
         cycle();
         #1;
         check("alt_owner", rsp_valid, (i % 2 == 0) ? 2'b10 : 2'b01);
         check("alt_result", rsp_result, (i % 2 == 0) ? 32'hFF : 32'h0);
         check("alt_zero", rsp_zero, (i % 2 == 0) ? 1'b0 : 1'b1);
      end

      // stall with the owner not ready while req1 waits
      req_valid  = 2'b01;
      req_sel[0] = ALU_SLT;
      req_op1[0] = 32'hFFFF_FFFF;
      req_op2[0] = 32'd1;
      cycle();
      req_valid = 2'b10;
      rsp_ready = 2'b10;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_ready", req_ready, 2'b00);
         check("stall_result", rsp_result, 32'd1);
         cycle();
      end
      rsp_ready = 2'b01;
      #1;
      check("drain_accept", req_ready, 2'b10);
      cycle();
      #1;
      check("after_drain_owner", rsp_valid, 2'b10);
      check("after_drain_result", rsp_result, 32'hFF);

      // idle cycles keep the pointer
      req_valid = '0;
      rsp_ready = 2'b11;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("idle_pass_b", alu_sel, ALU_PASS_B);
         cycle();
      end
      check("idle_rsp_valid", rsp_valid, 2'b00);
      req_valid = 2'b11;
      #1;
      check("idle_rr_kept", req_ready, 2'b01);
      cycle();

      // reset while a response is pending
      req_valid  = 2'b01;
      req_sel[0] = ALU_SLL;
      req_op1[0] = 32'd1;
      req_op2[0] = 32'd4;
      cycle();
      req_valid = 2'b11;
      rsp_ready = 2'b00;
      #1;
      check("sll_valid", rsp_valid, 2'b01);
      check("sll_result", rsp_result, 32'd16);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rsp_valid", rsp_valid, 2'b00);
      check("async_req_ready", req_ready, 2'b00);
      @(negedge clk);
      model_reset();
      check("rst_result", rsp_result, 32'd0);
      check("rst_tag", rsp_tag, 4'd0);
      rst_n     = 1'b1;
      rsp_ready = 2'b11;
      #1;
      check("post_reset_grant", req_ready, 2'b01);
      cycle();

      // randomized traffic against the model
      for (int i = 0; i < 300; i++) begin
         for (int r = 0; r < N; r++) begin
            req_sel[r] = alu_sel_e'($urandom_range(0, 10));
            req_op1[r] = $urandom;
            req_op2[r] = ($urandom_range(0, 3) == 0) ? req_op1[r] : $urandom;
            req_tag[r] = TW'($urandom_range(0, 15));
         end
         req_valid = N'($urandom_range(0, 3));
         rsp_ready = N'($urandom_range(0, 3));
         cycle();
      end

      // three requesters, requester 1 idle
      req_valid = '0;
      v3        = 3'b101;
      rr3       = 3'b111;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("n3_grant", r3, (i % 2 == 0) ? 3'b001 : 3'b100);
         @(posedge clk);
         @(negedge clk);
         #1;
         check("n3_rsp_owner", rv3, (i % 2 == 0) ? 3'b001 : 3'b100);
      end
      v3 = '0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
